spi_master_multi: RTL and testbench

Parametrised SPI master for the serial peripheral subsystem. It supports configurable address and data widths, all four SPI modes (CPOL/CPHA), and several active-low slave selects. Each transaction is one frame: an 8-bit slave ID, then the address, then the data, all MSB first. Full-duplex readback is captured during the data phase, and the block sits between the register-bus control logic and the board-level SPI pins.

---
 rtl/spi_master_multi_if.sv | 32 +++
 rtl/spi_master_multi.sv | 156 +++++++++++++++
 tb/tb_spi_master_multi.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_multi_if.sv
// Control-side bus of spi_master_multi: frame request, configuration and readback.
// The master modport belongs to the requester and the slave modport to the SPI engine.
interface spi_master_multi_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 10
);
  localparam int SEL_W = $clog2(NUM_SS);

  logic [DIV_W-1:0]  freq;
  logic              cpol;
  logic              cpha;
  logic [SEL_W-1:0]  ss_sel;
  logic              start_wr;
  logic              start_re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;

  modport master (
    output freq, cpol, cpha, ss_sel, start_wr, start_re, addr, wdata,
    input  rdata, busy, done
  );

  modport slave (
    input  freq, cpol, cpha, ss_sel, start_wr, start_re, addr, wdata,
    output rdata, busy, done
  );
endinterface

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: one frame = {ID byte, addr, data}, MSB first, all four modes.
// Optional macro SPI_MASTER_LOOPBACK_EN adds a loopback input that samples the block's own mosi.
module spi_master_multi #(
  parameter int         ADDR_W    = 8,
  parameter int         DATA_W    = 8,
  parameter int         NUM_SS    = 4,
  parameter int         DIV_W     = 10,
  parameter logic [7:0] SLAVE_IDW = 8'hFF,
  parameter logic [7:0] SLAVE_IDR = 8'h00
) (
  input  logic              clock,
  input  logic              n_reset,
  spi_master_multi_if.slave bus,
  input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss
);
  localparam int SEL_W = $clog2(NUM_SS);
  localparam int F     = 8 + ADDR_W + DATA_W;
  localparam int E_W   = $clog2(2 * F + 1);
  localparam logic [E_W-1:0] LAST_EDGE = E_W'(2 * F);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  freq_q, freq_d;
  logic [E_W-1:0]    edge_q, edge_d;
  logic              cpha_q, cpha_d;
  logic              sclk_q, sclk_d;
  logic [F-1:0]      sr_q, sr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_SS-1:0] ss_q, ss_d;
  logic              done_q, done_d;
  logic [2:0]        wr_pipe_q, re_pipe_q;

  logic              wr_rise, re_rise;
  logic [E_W-1:0]    edge_k;
  logic              sample_bit;
  logic [DATA_W:0]   rdata_sh;
  logic [NUM_SS-1:0] sel_mask;

  // Stage 0 synchronises the request; stages 1 and 2 form the rising-edge detect.
  assign wr_rise = wr_pipe_q[1] & ~wr_pipe_q[2];
  assign re_rise = re_pipe_q[1] & ~re_pipe_q[2];

  // An out-of-range ss_sel matches no line, so the frame runs with nothing selected.
  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_sel
    assign sel_mask[gi] = (bus.ss_sel != SEL_W'(gi));
  end

  assign mosi = (state_q != IDLE) && sr_q[F-1];

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample_bit = loopback ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    freq_d   = freq_q;
    edge_d   = edge_q;
    cpha_d   = cpha_q;
    sclk_d   = sclk_q;
    sr_d     = sr_q;
    rdata_d  = rdata_q;
    ss_d     = ss_q;
    done_d   = done_q;
    edge_k   = edge_q + 1'b1;
    rdata_sh = {rdata_q, sample_bit};

    unique case (state_q)
      IDLE: begin
        if (wr_rise || re_rise) begin
          state_d = SETUP;
          cnt_d   = bus.freq;
          freq_d  = bus.freq;
          cpha_d  = bus.cpha;
          sclk_d  = bus.cpol;
          edge_d  = '0;
          done_d  = 1'b0;
          rdata_d = '0;
          ss_d    = sel_mask;
          if (!wr_rise) sr_d = {SLAVE_IDR, bus.addr, {DATA_W{1'b0}}};
          else          sr_d = {SLAVE_IDW, bus.addr, bus.wdata};
        end
      end
      SETUP, SHIFT: begin
        if (cnt_q == '0) begin
          // The SETUP timeout coincides with sclk edge 1; odd edge numbers are leading edges.
          cnt_d   = freq_q;
          edge_d  = edge_k;
          sclk_d  = ~sclk_q;
          state_d = (edge_k == LAST_EDGE) ? HOLD : SHIFT;
          if (edge_k[0] != cpha_q) rdata_d = rdata_sh[DATA_W-1:0];
          if (!cpha_q && !edge_k[0] && edge_k != LAST_EDGE) sr_d = sr_q << 1;
          if (cpha_q && edge_k[0] && edge_k != E_W'(1)) sr_d = sr_q << 1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ss_d    = '1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      freq_q    <= '0;
      edge_q    <= '0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sr_q      <= '0;
      rdata_q   <= '0;
      ss_q      <= '1;
      done_q    <= 1'b0;
      wr_pipe_q <= '0;
      re_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      freq_q    <= freq_d;
      edge_q    <= edge_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      sr_q      <= sr_d;
      rdata_q   <= rdata_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
      wr_pipe_q <= {wr_pipe_q[1:0], bus.start_wr};
      re_pipe_q <= {re_pipe_q[1:0], bus.start_re};
    end
  end

  assign sclk      = sclk_q;
  assign ss        = ss_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: an 8/8-bit and a 16/16-bit instance, random frames checked
// against a timing/frame model derived from the frame rules, plus a behavioural SPI slave.
`timescale 1ns/1ps
module tb_spi_master_multi;
  logic        clock = 1'b0;
  logic        n_reset;
  logic [9:0]  freq;
  logic        cpol, cpha;
  logic [3:0]  ss_sel;
  logic        start_wr, start_re;
  logic [15:0] addr, wdata;
  logic        miso;
  logic        loopback;
  int          inst;

  int tests = 0;
  int fails = 0;
  int frame_no = 0;

  always #5 clock = ~clock;

  spi_master_multi_if #(.ADDR_W(8),  .DATA_W(8),  .NUM_SS(4), .DIV_W(10)) bus_a ();
  spi_master_multi_if #(.ADDR_W(16), .DATA_W(16), .NUM_SS(6), .DIV_W(10)) bus_b ();

  assign bus_a.freq     = freq;
  assign bus_a.cpol     = cpol;
  assign bus_a.cpha     = cpha;
  assign bus_a.ss_sel   = ss_sel[1:0];
  assign bus_a.start_wr = start_wr && (inst == 0);
  assign bus_a.start_re = start_re && (inst == 0);
  assign bus_a.addr     = addr[7:0];
  assign bus_a.wdata    = wdata[7:0];
  assign bus_b.freq     = freq;
  assign bus_b.cpol     = cpol;
  assign bus_b.cpha     = cpha;
  assign bus_b.ss_sel   = ss_sel[2:0];
  assign bus_b.start_wr = start_wr && (inst == 1);
  assign bus_b.start_re = start_re && (inst == 1);
  assign bus_b.addr     = addr;
  assign bus_b.wdata    = wdata;

  logic       sclk_a, mosi_a, sclk_b, mosi_b;
  logic [3:0] ss_a;
  logic [5:0] ss_b;

  spi_master_multi #(.ADDR_W(8), .DATA_W(8), .NUM_SS(4), .DIV_W(10)) dut_a (
    .clock    (clock),
    .n_reset  (n_reset),
    .bus      (bus_a),
    .miso     (miso),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback (loopback),
`endif
    .sclk     (sclk_a),
    .mosi     (mosi_a),
    .ss       (ss_a)
  );

  spi_master_multi #(.ADDR_W(16), .DATA_W(16), .NUM_SS(6), .DIV_W(10)) dut_b (
    .clock    (clock),
    .n_reset  (n_reset),
    .bus      (bus_b),
    .miso     (miso),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback (loopback),
`endif
    .sclk     (sclk_b),
    .mosi     (mosi_b),
    .ss       (ss_b)
  );

  logic        sclk_o, mosi_o, busy_o, done_o;
  logic [15:0] ss_o, rdata_o;

  always_comb begin
    if (inst == 1) begin
      sclk_o = sclk_b; mosi_o = mosi_b; busy_o = bus_b.busy; done_o = bus_b.done;
      ss_o = {10'h3FF, ss_b}; rdata_o = bus_b.rdata;
    end else begin
      sclk_o = sclk_a; mosi_o = mosi_a; busy_o = bus_a.busy; done_o = bus_a.done;
      ss_o = {12'hFFF, ss_a}; rdata_o = {8'h00, bus_a.rdata};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " sclk"},  sclk_o,  1'b0);
    chk({tag, " mosi"},  mosi_o,  1'b0);
    chk({tag, " ss"},    ss_o,    16'hFFFF);
    chk({tag, " rdata"}, rdata_o, 16'h0);
    chk({tag, " busy"},  busy_o,  1'b0);
    chk({tag, " done"},  done_o,  1'b0);
  endtask

  // One frame: request at T, then every cycle compare against the frame timing rules.
  // abort_at>0 asserts n_reset once that many sclk edges are seen; drop_at>0 pulses start_re mid-frame.
  task automatic run_frame(input int which, input bit rd, input bit both, input int fq,
                           input bit pol, input bit pha, input int sel,
                           input logic [15:0] a, input logic [15:0] wd, input logic [63:0] resp,
                           input bit lb, input int abort_at, input int drop_at);
    int aw, dw, ns, f, h, e, k, nedge, nsamp;
    logic [63:0] exp_frame, got, fmask, amask, dmask;
    logic [15:0] exp_ss, exp_rd;
    logic        prev_sclk;
    string       pre;
    aw = (which == 1) ? 16 : 8;
    dw = aw;
    ns = (which == 1) ? 6 : 4;
    f  = 8 + aw + dw;
    h  = fq + 1;
    e  = 2 + (2 * f + 1) * h;
    fmask = (64'd1 << f) - 64'd1;
    amask = (64'd1 << aw) - 64'd1;
    dmask = (64'd1 << dw) - 64'd1;
    exp_frame = ((rd && !both) ? 64'h00 : 64'hFF) << (aw + dw);
    exp_frame = exp_frame | ((64'(a) & amask) << dw);
    if (!rd || both) exp_frame = exp_frame | (64'(wd) & dmask);
    exp_ss = 16'hFFFF;
    if (sel < ns) exp_ss[sel] = 1'b0;
    exp_rd = lb ? 16'(exp_frame & dmask) : 16'(resp & dmask);
    frame_no++;
    pre = $sformatf("f%0d", frame_no);
    $display("[TB] frame %0d inst=%0d rd=%0d both=%0d cpol=%0d cpha=%0d freq=%0d sel=%0d addr=%h wdata=%h lb=%0d",
             frame_no, which, rd, both, pol, pha, fq, sel, a, wd, lb);

    @(negedge clock);
    inst = which; freq = 10'(fq); cpol = pol; cpha = pha; ss_sel = 4'(sel);
    addr = a; wdata = wd; loopback = lb; miso = resp[f-1];
    start_wr = !rd || both;
    start_re = rd || both;
    @(posedge clock);
    nedge = 0; nsamp = 0; got = '0; prev_sclk = pol;
    for (int c = 1; c <= e; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (c == 1) begin
        start_wr = 1'b0; start_re = 1'b0;
        chk({pre, " busy before accept"}, busy_o, 1'b0);
        continue;
      end
      if (c == 2) begin
        chk({pre, " rdata cleared"}, rdata_o, 16'h0);
        chk({pre, " mosi first bit"}, mosi_o, exp_frame[f-1]);
        prev_sclk = sclk_o;
      end
      if (c == 3) begin
        freq = 10'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
        ss_sel = 4'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
      end
      if (drop_at > 0 && c == drop_at) start_re = 1'b1;
      if (drop_at > 0 && c == drop_at + 3) start_re = 1'b0;
      if (sclk_o !== prev_sclk) begin
        nedge++;
        prev_sclk = sclk_o;
        if ((nedge % 2 == 1) != pha) begin
          got = {got[62:0], mosi_o};
          nsamp++;
          if (nsamp < f) miso = resp[f-1-nsamp];
        end
      end
      if (abort_at > 0 && nedge == abort_at) begin
        n_reset = 1'b0;
        #1;
        chk_reset_values({pre, " abort"});
        @(negedge clock);
        n_reset = 1'b1;
        @(negedge clock);
        chk({pre, " idle after abort"}, busy_o, 1'b0);
        return;
      end
      if (c < e) begin
        k = (c - 2) / h;
        if (k > 2 * f) k = 2 * f;
        chk($sformatf("%s sclk c%0d", pre, c), sclk_o, pol ^ k[0]);
        chk($sformatf("%s ss c%0d", pre, c), ss_o, exp_ss);
        chk($sformatf("%s busy c%0d", pre, c), busy_o, 1'b1);
        chk($sformatf("%s done c%0d", pre, c), done_o, 1'b0);
      end else begin
        chk({pre, " end busy"},  busy_o,  1'b0);
        chk({pre, " end done"},  done_o,  1'b1);
        chk({pre, " end ss"},    ss_o,    16'hFFFF);
        chk({pre, " end sclk"},  sclk_o,  pol);
        chk({pre, " end mosi"},  mosi_o,  1'b0);
        chk({pre, " rdata"},     rdata_o, exp_rd);
        chk({pre, " edges"},     64'(nedge), 64'(2 * f));
        chk({pre, " mosi frame"}, got & fmask, exp_frame);
      end
    end
    repeat (3) begin
      @(negedge clock);
      chk({pre, " idle busy"}, busy_o, 1'b0);
      chk({pre, " idle done"}, done_o, 1'b1);
      chk({pre, " idle sclk"}, sclk_o, pol);
      chk({pre, " idle mosi"}, mosi_o, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] r;
    int w;
    n_reset = 1'b0; inst = 0; freq = '0; cpol = 1'b0; cpha = 1'b0; ss_sel = '0;
    start_wr = 1'b0; start_re = 1'b0; addr = '0; wdata = '0; miso = 1'b0; loopback = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_values("reset inst0");
    inst = 1;
    #1;
    chk_reset_values("reset inst1");
    inst = 0;
    n_reset = 1'b1;
    repeat (2) @(negedge clock);

    run_frame(0, 0, 0, 0, 0, 0, 0, 16'h5A, 16'hC3, {$urandom, $urandom}, 0, 0, 0);
    r = {$urandom, $urandom}; r[7:0] = 8'hA5;
    run_frame(0, 1, 0, 3, 1, 1, 1, 16'($urandom), 16'($urandom), r, 0, 0, 0);
    run_frame(0, 0, 0, 1, 0, 1, 2, 16'($urandom), 16'($urandom), {$urandom, $urandom}, 0, 0, 0);
    run_frame(1, 0, 0, 0, 1, 0, 3, 16'($urandom), 16'($urandom), {$urandom, $urandom}, 0, 0, 0);
    run_frame(1, 1, 0, 2, 0, 1, 7, 16'($urandom), 16'($urandom), {$urandom, $urandom}, 0, 0, 0);
    run_frame(0, 1, 1, 0, 1, 0, 3, 16'($urandom), 16'($urandom), {$urandom, $urandom}, 0, 0, 0);
    run_frame(0, 1, 0, 0, 0, 0, 0, 16'($urandom), 16'($urandom), {$urandom, $urandom}, 0, 0, 20);
    run_frame(0, 0, 0, 0, 0, 0, 1, 16'($urandom), 16'($urandom), {$urandom, $urandom}, 0, 0, 0);
    run_frame(0, 0, 0, 0, 1, 1, 0, 16'($urandom), 16'($urandom), {$urandom, $urandom}, 0, 20, 0);
    run_frame(0, 0, 0, 0, 0, 0, 2, 16'h77, 16'h81, {$urandom, $urandom}, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(0, 1);
      run_frame(w, 1'($urandom), 1'b0, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                (w == 1) ? $urandom_range(0, 7) : $urandom_range(0, 3),
                16'($urandom), 16'($urandom), {$urandom, $urandom}, 0, 0, 0);
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    run_frame(0, 0, 0, 0, 0, 0, 0, 16'($urandom), 16'h3C, {$urandom, $urandom}, 1, 0, 0);
    loopback = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
